// File: rtl/snake_game_ctrl.sv
// Snake game controller: UART direction/start/pause command decode, direction
// queue, frame-based step timing and game state machine.
module snake_game_ctrl #(
    parameter int FIFO_DEPTH      = 4,
    parameter int FRAMES_PER_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dataRX,
    input  logic        WR_RX,
    input  logic        frame_end,
    input  logic        collision,
    output logic        step,
    output logic        dir_valid,
    output logic [1:0]  dir,
    output logic        restart,
    output logic [1:0]  state,
    output logic        cmd_drop,
    output logic [15:0] steps
);
    localparam int              PW         = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
    localparam logic [PW:0]     CNT_ONE    = (PW+1)'(1);
    localparam logic [PW:0]     CNT_FULL   = (PW+1)'(FIFO_DEPTH);
    localparam logic [7:0]      FRAME_LAST = 8'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_OVER = 2'b11} state_t;
    typedef enum logic [1:0] {K_NONE = 2'b00, K_DIR = 2'b01, K_START = 2'b10, K_PAUSE = 2'b11} cmd_t;

    logic          r_wr_prev;
    logic          r_byte_vld;
    logic [7:0]    r_byte;
    cmd_t          r_cmd;
    logic [1:0]    r_cmd_dir;
    state_t        r_state;
    logic [1:0]    r_dir;
    logic          r_step;
    logic          r_dir_valid;
    logic          r_restart;
    logic          r_cmd_drop;
    logic [15:0]   r_steps;
    logic [7:0]    r_frame_cnt;
    logic [1:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;

    cmd_t          w_kind;
    logic [1:0]    w_ddir;
    logic          w_run;
    logic          w_coll;
    logic          w_step;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_restart;
    logic [1:0]    w_ref;

    // Byte decode of the captured UART byte
    always_comb begin
        w_kind = K_NONE;
        w_ddir = 2'b00;
        case (r_byte)
            8'h41:   begin w_kind = K_DIR; w_ddir = 2'b10; end
            8'h42:   begin w_kind = K_DIR; w_ddir = 2'b11; end
            8'h43:   begin w_kind = K_DIR; w_ddir = 2'b00; end
            8'h44:   begin w_kind = K_DIR; w_ddir = 2'b01; end
            8'h53:   w_kind = K_START;
            8'h50:   w_kind = K_PAUSE;
            default: w_kind = K_NONE;
        endcase
    end

    // Step, queue and command acceptance decisions; collision outranks a step
    always_comb begin
        w_run     = (r_state == S_RUN);
        w_coll    = w_run & collision;
        w_step    = w_run & ~w_coll & frame_end & (r_frame_cnt == FRAME_LAST);
        w_pop     = w_step & (r_count != '0);
        w_ref     = (r_count != '0) ? r_fifo[r_wr_ptr - PTR_ONE] : r_dir;
        w_push    = (r_cmd == K_DIR) & w_run & (r_cmd_dir[1] != w_ref[1])
                    & ((r_count != CNT_FULL) | w_pop);
        w_drop    = (r_cmd == K_DIR) & ~w_push;
        w_restart = (r_cmd == K_START) & ((r_state == S_IDLE) | (r_state == S_OVER));
    end

    // Rising-edge byte capture followed by one registered decode stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_prev  <= 1'b1;
            r_byte_vld <= 1'b0;
            r_byte     <= 8'h00;
            r_cmd      <= K_NONE;
            r_cmd_dir  <= 2'b00;
        end else begin
            r_wr_prev  <= WR_RX;
            r_byte_vld <= WR_RX & ~r_wr_prev;
            if (WR_RX && !r_wr_prev) begin
                r_byte <= dataRX;
            end
            r_cmd      <= r_byte_vld ? w_kind : K_NONE;
            r_cmd_dir  <= w_ddir;
        end
    end

    // Game state, direction queue, frame counter and pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dir       <= 2'b00;
            r_step      <= 1'b0;
            r_dir_valid <= 1'b0;
            r_restart   <= 1'b0;
            r_cmd_drop  <= 1'b0;
            r_steps     <= 16'h0000;
            r_frame_cnt <= 8'h00;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= 2'b00;
            end
        end else begin
            r_step      <= 1'b0;
            r_dir_valid <= 1'b0;
            r_restart   <= 1'b0;
            r_cmd_drop  <= w_drop;

            if (w_push) begin
                r_fifo[r_wr_ptr] <= r_cmd_dir;
                r_wr_ptr         <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_dir       <= r_fifo[r_rd_ptr];
                r_dir_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_step) begin
                r_step <= 1'b1;
                if (r_steps != 16'hFFFF) begin
                    r_steps <= r_steps + 16'd1;
                end
            end

            if (w_run && !w_coll && frame_end) begin
                r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? 8'h00 : r_frame_cnt + 8'd1;
            end else if (w_coll || r_state == S_IDLE || r_state == S_OVER) begin
                r_frame_cnt <= 8'h00;
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end

            // Restart assignments come last so they override queue/counter updates
            if (w_coll) begin
                r_state <= S_OVER;
            end else if (w_restart) begin
                r_state     <= S_RUN;
                r_restart   <= 1'b1;
                r_dir       <= 2'b00;
                r_rd_ptr    <= '0;
                r_wr_ptr    <= '0;
                r_count     <= '0;
                r_steps     <= 16'h0000;
                r_frame_cnt <= 8'h00;
            end else if (r_cmd == K_PAUSE && r_state == S_RUN) begin
                r_state <= S_PAUSE;
            end else if (r_cmd == K_PAUSE && r_state == S_PAUSE) begin
                r_state <= S_RUN;
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign step      = r_step;
    assign dir_valid = r_dir_valid;
    assign dir       = r_dir;
    assign restart   = r_restart;
    assign state     = r_state;
    assign cmd_drop  = r_cmd_drop;
    assign steps     = r_steps;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed self-checking bench for snake_game_ctrl (FIFO_DEPTH=4, FRAMES_PER_STEP=3).
module tb_snake_game_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dataRX;
    logic        WR_RX;
    logic        frame_end;
    logic        collision;
    logic        step;
    logic        dir_valid;
    logic [1:0]  dir;
    logic        restart;
    logic [1:0]  state;
    logic        cmd_drop;
    logic [15:0] steps;

    int n_checks = 0;
    int n_fail   = 0;

    snake_game_ctrl #(.FIFO_DEPTH(4), .FRAMES_PER_STEP(3)) dut (
        .clk(clk), .rst(rst), .dataRX(dataRX), .WR_RX(WR_RX),
        .frame_end(frame_end), .collision(collision), .step(step),
        .dir_valid(dir_valid), .dir(dir), .restart(restart), .state(state),
        .cmd_drop(cmd_drop), .steps(steps)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the decode stage acts, when cmd_drop/restart are visible
    task automatic send_byte(input logic [7:0] b);
        dataRX = b;
        WR_RX  = 1'b1;
        cyc();
        WR_RX  = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic pulse_frame();
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; WR_RX = 1'b1; dataRX = 8'h53; frame_end = 1'b0; collision = 1'b0;
        cyc(); cyc();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", state); end
        n_checks++; if (dir !== 2'b00) begin n_fail++; $display("FAIL reset_dir: got %b want 00", dir); end
        n_checks++; if (steps !== 16'h0000) begin n_fail++; $display("FAIL reset_steps: got %h want 0000", steps); end
        n_checks++; if ({step, dir_valid, restart, cmd_drop} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 0000", {step, dir_valid, restart, cmd_drop}); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_wr_held: got %b want 00", state); end
        WR_RX = 1'b0;
        cyc();
    endtask

    task automatic test_idle_drop();
        send_byte(8'h43);
        n_checks++; if (cmd_drop !== 1'b1) begin n_fail++; $display("FAIL idle_dir_drop: got %b want 1", cmd_drop); end
        send_byte(8'h78);
        n_checks++; if (cmd_drop !== 1'b0) begin n_fail++; $display("FAIL idle_junk_nodrop: got %b want 0", cmd_drop); end
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL idle_hold: got %b want 00", state); end
    endtask

    task automatic test_start();
        send_byte(8'h53);
        n_checks++; if (restart !== 1'b1) begin n_fail++; $display("FAIL start_restart: got %b want 1", restart); end
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL start_state: got %b want 01", state); end
        n_checks++; if (dir !== 2'b00 || steps !== 16'h0000) begin
            n_fail++; $display("FAIL start_dir_steps: got dir=%b steps=%0d want 00/0", dir, steps); end
        cyc();
        n_checks++; if (restart !== 1'b0) begin n_fail++; $display("FAIL start_restart_once: got %b want 0", restart); end
    endtask

    task automatic test_frames();
        for (int i = 1; i <= 9; i++) begin
            pulse_frame();
            n_checks++; if (step !== ((i % 3) == 0)) begin
                n_fail++; $display("FAIL frame_step_%0d: got %b want %b", i, step, (i % 3) == 0); end
            cyc();
            n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL frame_step_width_%0d: got %b want 0", i, step); end
        end
        n_checks++; if (steps !== 16'd3) begin n_fail++; $display("FAIL frame_steps: got %0d want 3", steps); end
    endtask

    task automatic test_dir_filter();
        logic [3:0] drops;
        send_byte(8'h44); drops[3] = cmd_drop;
        send_byte(8'h41); drops[2] = cmd_drop;
        send_byte(8'h41); drops[1] = cmd_drop;
        send_byte(8'h42); drops[0] = cmd_drop;
        n_checks++; if (drops !== 4'b1011) begin n_fail++; $display("FAIL filter_drops: got %b want 1011", drops); end
        pulse_frame(); pulse_frame(); pulse_frame();
        n_checks++; if ({step, dir_valid, dir} !== 4'b1110) begin
            n_fail++; $display("FAIL filter_pop: got step/dv/dir=%b want 1110", {step, dir_valid, dir}); end
    endtask

    task automatic test_fifo_full();
        logic [4:0] drops;
        logic [1:0] exp_dir [4];
        exp_dir[0] = 2'b00; exp_dir[1] = 2'b10; exp_dir[2] = 2'b01; exp_dir[3] = 2'b10;
        send_byte(8'h43); drops[4] = cmd_drop;
        send_byte(8'h41); drops[3] = cmd_drop;
        send_byte(8'h44); drops[2] = cmd_drop;
        send_byte(8'h41); drops[1] = cmd_drop;
        send_byte(8'h43); drops[0] = cmd_drop;
        n_checks++; if (drops !== 5'b00001) begin n_fail++; $display("FAIL full_drops: got %b want 00001", drops); end
        for (int i = 0; i < 4; i++) begin
            pulse_frame(); pulse_frame(); pulse_frame();
            n_checks++; if ({step, dir_valid, dir} !== {2'b11, exp_dir[i]}) begin
                n_fail++; $display("FAIL full_pop_%0d: got %b want %b", i, {step, dir_valid, dir}, {2'b11, exp_dir[i]}); end
        end
        pulse_frame(); pulse_frame(); pulse_frame();
        n_checks++; if ({step, dir_valid, dir} !== 4'b1010) begin
            n_fail++; $display("FAIL full_empty_step: got %b want 1010", {step, dir_valid, dir}); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_dir [4];
        exp_dir[0] = 2'b10; exp_dir[1] = 2'b00; exp_dir[2] = 2'b10; exp_dir[3] = 2'b00;
        send_byte(8'h43); send_byte(8'h41); send_byte(8'h43); send_byte(8'h41);
        pulse_frame(); pulse_frame();
        dataRX = 8'h43; WR_RX = 1'b1;
        cyc();
        WR_RX = 1'b0;
        cyc();
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
        n_checks++; if ({step, dir_valid, dir, cmd_drop} !== 5'b11000) begin
            n_fail++; $display("FAIL b2b_push_pop: got step/dv/dir/drop=%b want 11000", {step, dir_valid, dir, cmd_drop}); end
        for (int i = 0; i < 4; i++) begin
            pulse_frame(); pulse_frame(); pulse_frame();
            n_checks++; if ({step, dir_valid, dir} !== {2'b11, exp_dir[i]}) begin
                n_fail++; $display("FAIL b2b_pop_%0d: got %b want %b", i, {step, dir_valid, dir}, {2'b11, exp_dir[i]}); end
        end
        n_checks++; if (steps !== 16'd14) begin n_fail++; $display("FAIL b2b_steps: got %0d want 14", steps); end
    endtask

    task automatic test_pause();
        int nsteps;
        pulse_frame();
        send_byte(8'h50);
        n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL pause_state: got %b want 10", state); end
        send_byte(8'h41);
        n_checks++; if (cmd_drop !== 1'b1) begin n_fail++; $display("FAIL pause_dir_drop: got %b want 1", cmd_drop); end
        nsteps = 0;
        for (int i = 0; i < 10; i++) begin
            pulse_frame();
            if (step === 1'b1) nsteps++;
        end
        n_checks++; if (nsteps != 0) begin n_fail++; $display("FAIL pause_nostep: got %0d want 0", nsteps); end
        send_byte(8'h50);
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL resume_state: got %b want 01", state); end
        pulse_frame();
        n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL resume_early: got %b want 0", step); end
        pulse_frame();
        n_checks++; if (step !== 1'b1) begin n_fail++; $display("FAIL resume_step: got %b want 1", step); end
    endtask

    task automatic test_collision();
        send_byte(8'h41);
        pulse_frame(); pulse_frame();
        frame_end = 1'b1; collision = 1'b1;
        cyc();
        frame_end = 1'b0; collision = 1'b0;
        n_checks++; if ({step, dir_valid, state, dir} !== 6'b001100) begin
            n_fail++; $display("FAIL coll_step: got step/dv/state/dir=%b want 001100", {step, dir_valid, state, dir}); end
        n_checks++; if (steps !== 16'd15) begin n_fail++; $display("FAIL coll_steps: got %0d want 15", steps); end
        send_byte(8'h41);
        n_checks++; if (cmd_drop !== 1'b1) begin n_fail++; $display("FAIL over_dir_drop: got %b want 1", cmd_drop); end
        send_byte(8'h53);
        n_checks++; if ({restart, state, dir} !== 5'b10100 || steps !== 16'h0000) begin
            n_fail++; $display("FAIL over_restart: got rs/state/dir=%b steps=%0d want 10100/0", {restart, state, dir}, steps); end
        pulse_frame(); pulse_frame(); pulse_frame();
        n_checks++; if ({step, dir_valid, dir} !== 4'b1000 || steps !== 16'd1) begin
            n_fail++; $display("FAIL restart_fifo_empty: got %b steps=%0d want 1000/1", {step, dir_valid, dir}, steps); end
    endtask

    initial begin
        test_reset();
        test_idle_drop();
        test_start();
        test_frames();
        test_dir_filter();
        test_fifo_full();
        test_back_to_back();
        test_pause();
        test_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL: FIFO_DEPTH, 4, direction-command queue depth (power of two, 2..16).
REQ-002 SHALL: FRAMES_PER_STEP, 1, frame_end pulses per snake movement step (1..255).
REQ-003 SHALL: clk  in  1  single clock; all logic on posedge clk.
REQ-004 SHALL: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL: dataRX  in  8  UART received byte.
REQ-006 SHALL: WR_RX  in  1  high while dataRX valid; may stay high for many cycles.
REQ-007 SHALL: frame_end  in  1  one-cycle pulse at the last visible pixel (639,479).
REQ-008 SHALL: collision  in  1  level; snake hit itself or frame.
REQ-009 SHALL: step  out  1  one-cycle pulse; datapath advances head/tail by one pixel.
REQ-010 SHALL: dir_valid  out  1  one-cycle pulse, only coincident with step; new head direction on dir.
REQ-011 SHALL: dir  out  2  head direction; right=00, left=01, up=10, down=11.
REQ-012 SHALL: restart  out  1  one-cycle pulse; datapath reloads initial positions and clears segment registers.
REQ-013 SHALL: state  out  2  IDLE=00, RUN=01, PAUSE=10, OVER=11.
REQ-014 SHALL: cmd_drop  out  1  one-cycle pulse when a direction byte is rejected.
REQ-015 SHALL: steps  out  16  steps taken since last restart, saturating at 0xFFFF.

Function
REQ-016 SHALL: byte capture on WR_RX rising edge only (WR_RX & ~wr_prev); byte registered in cycle n, decoded in n+1, effect visible at outputs/FIFO in n+2.
REQ-017 SHALL: decode 'A'(0x41)=up, 'B'(0x42)=down, 'C'(0x43)=right, 'D'(0x44)=left, 'S'(0x53)=start, 'P'(0x50)=pause; all other bytes ignored silently (no cmd_drop).
REQ-018 SHALL: IDLE --'S'--> RUN; OVER --'S'--> RUN; RUN --'P'--> PAUSE; PAUSE --'P'--> RUN; RUN --collision--> OVER; all other byte/state pairs hold state.
REQ-019 SHALL: on entry to RUN from IDLE or OVER: restart pulse, FIFO emptied, dir=right, frame counter=0, steps=0, all in the same cycle.
REQ-020 SHALL: direction bytes accepted only in RUN; in IDLE/PAUSE/OVER rejected with cmd_drop.
REQ-021 SHALL: reference direction = FIFO tail entry if non-empty, else dir; byte rejected (cmd_drop) if equal to reference or its opposite (same bit1, different bit0).
REQ-022 SHALL: byte rejected (cmd_drop) when FIFO full, unless a pop occurs in the same cycle, in which case it is accepted.
REQ-023 SHALL: frame counter increments on frame_end in RUN only; holds in PAUSE; cleared in IDLE/OVER.
REQ-024 SHALL: when frame_end arrives with counter = FRAMES_PER_STEP-1: step pulses next cycle, counter returns to 0.
REQ-025 SHALL: on step, if FIFO non-empty, pop head into dir and pulse dir_valid same cycle; if empty, dir unchanged, dir_valid low.
REQ-026 SHALL: at most one FIFO pop per step; simultaneous push and pop both complete, occupancy unchanged.
REQ-027 SHALL: collision sampled only in RUN; collision has priority over a pending step in the same cycle (no step, no pop, enter OVER).
REQ-028 SHALL: steps increments on every step pulse; saturates at 0xFFFF.
REQ-029 SHALL: 'P' and collision in the same cycle -> OVER.
REQ-030 SHALL: collision while entering RUN via restart is ignored for that cycle.

Reset
REQ-031 SHALL: rst asserted forces immediately state=IDLE, dir=right, step=dir_valid=restart=cmd_drop=0, steps=0, FIFO empty, frame counter=0, wr_prev=1.
REQ-032 SHALL: rst mid-game aborts all pending commands; WR_RX held high through reset release produces no capture.

Verification
REQ-033 SHALL: rst release, 'S' byte -> restart pulse once, state=01, dir=00, steps=0.
REQ-034 SHALL: FRAMES_PER_STEP=3, RUN, 9 frame_end pulses -> exactly 3 step pulses, steps=3, each 1 cycle after 3rd/6th/9th frame_end.
REQ-035 SHALL: RUN dir=right, bytes 'D','A','A','B' -> 'D' dropped (reversal), 'A' queued, second 'A' dropped (duplicate), 'B' dropped (reversal of tail); next step gives dir=10 with dir_valid.
REQ-036 SHALL: FIFO_DEPTH=4, five alternating legal bytes with no step -> four queued, fifth cmd_drop; four steps pop them in order.
REQ-037 SHALL: 'P' in RUN then 10 frame_end -> no step, state=10; second 'P' -> state=01, counting resumes from held value.
REQ-038 SHALL: collision coincident with step cycle -> no step, state=11; 'S' -> restart, steps=0, FIFO empty.
